lock_timer_sched: RTL and testbench

- Shared timebase and timeout scheduler for the VGA lock.
- Owns one prescaler that turns the 25 MHz pixel clock into a 50 ms tick.
- Runs NUM_CH independent countdown channels (e.g. entry timeout, lockout, cursor blink, message hold) off that single tick, so requesters share one counter instead of each instantiating its own divider.
- Outputs one-cycle done pulses and a 50%-duty blink level to the lock FSM and display logic.

---
 rtl/lock_timer_sched_pkg.sv | 22 ++
 rtl/lock_timer_sched_if.sv | 26 ++
 rtl/lock_timer_sched_prescaler.sv | 42 ++++
 rtl/lock_timer_sched.sv | 83 ++++++++
 tb/tb_lock_timer_sched.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_timer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Purpose  : Shared constants for the VGA lock timebase and timeout scheduler.
// Revision : 1.0  initial release
// ============================================================================
package lock_pkg;

  localparam int NUM_CH       = 4;
  localparam int DUR_W        = 8;
  localparam int TICK_DIV_25M = 1250000;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int CH_ENTRY   = 0;
  localparam int CH_LOCKOUT = 1;
  localparam int CH_BLINK   = 2;
  localparam int CH_MSG     = 3;

endpackage
`default_nettype wire

// File: rtl/lock_timer_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer_sched_if
// Purpose  : Requester-side bundle of strobes, durations and timer status.
// Revision : 1.0  initial release
// ============================================================================
interface lock_timer_sched_if
  import lock_pkg::*;
#(
  parameter int NUM_CH = lock_pkg::NUM_CH,
  parameter int DUR_W  = lock_pkg::DUR_W
);

  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH*DUR_W-1:0] dur;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic                    tick;
  logic                    blink;

  modport master (output start, cancel, dur, input busy, done, tick, blink);
  modport slave  (input start, cancel, dur, output busy, done, tick, blink);

endinterface
`default_nettype wire

// File: rtl/lock_timer_sched_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Free-running divider producing a one-cycle tick and a blink level.
// Revision : 1.0  initial release
// ============================================================================
module tick_prescaler #(
  parameter int TICK_DIV = lock_pkg::TICK_DIV_25M,
  parameter int CNT_W    = 21
) (
  input  wire logic clk_in,
  input  wire logic rst,
  output logic      tick,
  output logic      blink
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_blink;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_blink <= 1'b0;
    end else if (r_cnt == c_last) begin
      r_cnt   <= '0;
      r_tick  <= 1'b1;
      r_blink <= ~r_blink;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick  = r_tick;
  assign blink = r_blink;

endmodule
`default_nettype wire

// File: rtl/lock_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer_sched
// Purpose  : One shared prescaler driving NUM_CH independent countdown channels.
// Revision : 1.0  initial release
// ============================================================================
module lock_timer_sched
  import lock_pkg::*;
#(
  parameter int NUM_CH   = lock_pkg::NUM_CH,
  parameter int TICK_DIV = lock_pkg::TICK_DIV_25M,
  parameter int CNT_W    = 21,
  parameter int DUR_W    = lock_pkg::DUR_W
) (
  input  wire logic          clk_in,
  input  wire logic          rst,
  lock_timer_sched_if.slave  bus
);

  logic w_tick;
  logic w_blink;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst    (rst),
    .tick   (w_tick),
    .blink  (w_blink)
  );

  assign bus.tick  = w_tick;
  assign bus.blink = w_blink;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [0:0]       r_state;
      logic [DUR_W-1:0] r_rem;
      logic             r_done;
      logic [DUR_W-1:0] w_dur;

      assign w_dur = bus.dur[g*DUR_W +: DUR_W];

      // cancel beats start beats tick; a tick landing with start is dropped
      always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
          r_state <= IDLE;
          r_rem   <= '0;
          r_done  <= 1'b0;
        end else begin
          r_done <= 1'b0;
          if (bus.cancel[g]) begin
            r_state <= IDLE;
            r_rem   <= '0;
          end else if (bus.start[g]) begin
            if (w_dur != '0) begin
              r_state <= RUN;
              r_rem   <= w_dur;
            end else begin
              r_state <= IDLE;
              r_rem   <= '0;
              r_done  <= 1'b1;
            end
          end else if (r_state == RUN && w_tick) begin
            if (r_rem == DUR_W'(1)) begin
              r_state <= IDLE;
              r_rem   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_rem <= r_rem - 1'b1;
            end
          end
        end
      end

      assign bus.busy[g] = (r_state == RUN);
      assign bus.done[g] = r_done;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lock_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_timer_sched
// Purpose  : Self-checking bench for lock_timer_sched with a deadline model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lock_timer_sched;
  import lock_pkg::*;

  localparam int TD = 4;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  lock_timer_sched_if bus ();

  lock_timer_sched #(
    .NUM_CH   (NUM_CH),
    .TICK_DIV (TD),
    .CNT_W    (3),
    .DUR_W    (DUR_W)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // cyc = rising edges since reset release; dl[ch] = edge after which done shows
  int cyc;
  int dl [NUM_CH];
  int n_checks = 0;
  int n_pass   = 0;
  logic [NUM_CH-1:0] exp_busy, exp_done;
  logic exp_tick, exp_blink;

  function automatic int next_tick_edge(input int e);
    return TD * ((e - 1) / TD + 1) + 1;
  endfunction

  task automatic model_clear();
    cyc = 0;
    for (int ch = 0; ch < NUM_CH; ch++) dl[ch] = -1;
  endtask

  task automatic step();
    int d;
    @(posedge clk_in);
    cyc++;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (bus.cancel[ch]) dl[ch] = -1;
      else if (bus.start[ch]) begin
        d = int'(bus.dur[ch*DUR_W +: DUR_W]);
        dl[ch] = (d == 0) ? cyc : next_tick_edge(cyc) + TD * (d - 1);
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_busy[ch] = (cyc < dl[ch]);
      exp_done[ch] = (cyc == dl[ch]);
    end
    exp_tick  = (cyc > 0) && (cyc % TD == 0);
    exp_blink = ((cyc / TD) % 2) == 1;
    @(negedge clk_in);
    bus.start  = '0;
    bus.cancel = '0;
  endtask

  task automatic test_reset();
    bus.start = '0; bus.cancel = '0; bus.dur = '0;
    rst = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if ({bus.busy, bus.done, bus.tick, bus.blink} !== '0)
      $display("FAIL reset_state got=%b/%b/%b/%b exp=0", bus.busy, bus.done, bus.tick, bus.blink);
    else n_pass++;
    rst = 1'b1;
    repeat (12) begin
      step();
      n_checks++;
      if ({bus.busy, bus.done, bus.tick, bus.blink} !== {exp_busy, exp_done, exp_tick, exp_blink})
        $display("FAIL reset_tick cyc=%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b", cyc, bus.busy, bus.done,
                 bus.tick, bus.blink, exp_busy, exp_done, exp_tick, exp_blink);
      else n_pass++;
    end
  endtask

  task automatic test_basic_expiry();
    int e, dc;
    dc = -1;
    bus.dur[0*DUR_W +: DUR_W] = 8'd3;
    bus.start[0] = 1'b1;
    step();
    e = cyc;
    n_checks++;
    if (bus.busy[0] !== 1'b1) $display("FAIL basic_busy got=%b exp=1", bus.busy[0]);
    else n_pass++;
    repeat (18) begin
      step();
      if (bus.done[0] === 1'b1) dc = cyc;
      n_checks++;
      if ({bus.busy, bus.done, bus.tick, bus.blink} !== {exp_busy, exp_done, exp_tick, exp_blink})
        $display("FAIL basic_cycle cyc=%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b", cyc, bus.busy, bus.done,
                 bus.tick, bus.blink, exp_busy, exp_done, exp_tick, exp_blink);
      else n_pass++;
    end
    n_checks++;
    if (dc - e < 9 || dc - e > 13) $display("FAIL basic_elapsed got=%0d exp=9..13", dc - e);
    else n_pass++;
  endtask

  task automatic test_cancel_priority();
    int nd = 0;
    int budget = 0;
    bus.dur[1*DUR_W +: DUR_W] = 8'd5;
    bus.start[1] = 1'b1;
    step();
    while (cyc < dl[1] - 1 && budget < 40) begin
      step();
      budget++;
      n_checks++;
      if ({bus.busy, bus.done} !== {exp_busy, exp_done})
        $display("FAIL cancel_run cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.busy, bus.done, exp_busy, exp_done);
      else n_pass++;
    end
    bus.cancel[1] = 1'b1;
    step();
    repeat (30) begin
      if (bus.done[1] === 1'b1) nd++;
      n_checks++;
      if ({bus.busy, bus.done, bus.tick} !== {exp_busy, exp_done, exp_tick})
        $display("FAIL cancel_cycle cyc=%0d got=%b/%b/%b exp=%b/%b/%b", cyc, bus.busy, bus.done, bus.tick,
                 exp_busy, exp_done, exp_tick);
      else n_pass++;
      step();
    end
    n_checks++;
    if (nd != 0) $display("FAIL cancel_no_done got=%0d exp=0", nd);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    int nd = 0;
    int dc = -1;
    int e2;
    bus.dur[2*DUR_W +: DUR_W] = 8'd2;
    bus.start[2] = 1'b1;
    step();
    e2 = next_tick_edge(cyc);
    while (cyc < e2) begin
      step();
      if (bus.done[2] === 1'b1) nd++;
    end
    bus.dur[2*DUR_W +: DUR_W] = 8'd4;
    bus.start[2] = 1'b1;
    step();
    e2 = cyc;
    repeat (25) begin
      step();
      if (bus.done[2] === 1'b1) begin nd++; dc = cyc; end
      n_checks++;
      if ({bus.busy, bus.done} !== {exp_busy, exp_done})
        $display("FAIL retrig_cycle cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.busy, bus.done, exp_busy, exp_done);
      else n_pass++;
    end
    n_checks++;
    if (nd != 1) $display("FAIL retrig_count got=%0d exp=1", nd);
    else n_pass++;
    n_checks++;
    if (dc != next_tick_edge(e2) + 3 * TD) $display("FAIL retrig_time got=%0d exp=%0d", dc, next_tick_edge(e2) + 3 * TD);
    else n_pass++;
  endtask

  task automatic test_zero_collision();
    int e;
    int budget = 0;
    bus.dur[3*DUR_W +: DUR_W] = 8'd0;
    bus.start[3] = 1'b1;
    step();
    n_checks++;
    if ({bus.busy[3], bus.done[3]} !== 2'b01) $display("FAIL zero_dur got=%b%b exp=01", bus.busy[3], bus.done[3]);
    else n_pass++;
    step();
    n_checks++;
    if ({bus.busy[3], bus.done[3]} !== 2'b00) $display("FAIL zero_after got=%b%b exp=00", bus.busy[3], bus.done[3]);
    else n_pass++;
    while (!exp_tick && budget < 2 * TD) begin step(); budget++; end
    bus.dur[0*DUR_W +: DUR_W] = 8'd1;
    bus.start[0] = 1'b1;
    step();
    e = cyc;
    repeat (TD + 2) begin
      n_checks++;
      if (bus.done[0] !== (cyc == e + TD) || bus.busy[0] !== (cyc < e + TD))
        $display("FAIL collide cyc=%0d got=%b%b exp=%b%b", cyc, bus.busy[0], bus.done[0],
                 cyc < e + TD, cyc == e + TD);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_async_reset();
    int nd = 0;
    for (int ch = 0; ch < NUM_CH; ch++) bus.dur[ch*DUR_W +: DUR_W] = 8'd5;
    bus.start = '1;
    step();
    repeat (TD + 1) step();
    n_checks++;
    if (bus.busy !== '1) $display("FAIL async_pre got=%b exp=1111", bus.busy);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.tick, bus.blink} !== '0)
      $display("FAIL async_clear got=%b/%b/%b/%b exp=0", bus.busy, bus.done, bus.tick, bus.blink);
    else n_pass++;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    model_clear();
    repeat (30) begin
      step();
      if (bus.done !== '0) nd++;
      n_checks++;
      if ({bus.busy, bus.done, bus.tick, bus.blink} !== {exp_busy, exp_done, exp_tick, exp_blink})
        $display("FAIL async_after cyc=%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b", cyc, bus.busy, bus.done,
                 bus.tick, bus.blink, exp_busy, exp_done, exp_tick, exp_blink);
      else n_pass++;
    end
    n_checks++;
    if (nd != 0) $display("FAIL async_no_done got=%0d exp=0", nd);
    else n_pass++;
  endtask

  task automatic test_random();
    repeat (600) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        bus.start[ch]  = ($urandom_range(0, 9) == 0);
        bus.cancel[ch] = ($urandom_range(0, 29) == 0);
        bus.dur[ch*DUR_W +: DUR_W] = DUR_W'($urandom_range(0, 6));
      end
      step();
      n_checks++;
      if ({bus.busy, bus.done, bus.tick, bus.blink} !== {exp_busy, exp_done, exp_tick, exp_blink})
        $display("FAIL random cyc=%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b", cyc, bus.busy, bus.done,
                 bus.tick, bus.blink, exp_busy, exp_done, exp_tick, exp_blink);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_expiry();
    test_cancel_priority();
    test_retrigger();
    test_zero_collision();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
